// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } rx_state_t;

  localparam int I2S_SLOT_WIDTH = 32;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings TCLK, WS and TD into the system clock domain and turns each TCLK rise
// into a registered one-cycle bit strobe.
module i2s_rx_sync
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tclk,
  input  logic ws,
  input  logic td,
  output logic ws_s,
  output logic td_s,
  output logic bit_stb
);

  logic [SYNC_STAGES-1:0] tclk_sr;
  logic [SYNC_STAGES-1:0] ws_sr;
  logic [SYNC_STAGES-1:0] td_sr;
  logic                   tclk_d;

  // SYNC_STAGES must be at least 2. The strobe is registered, so WS/TD are read
  // one cycle after TCLK settles, well inside the half-period data hold window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tclk_sr <= '0;
      ws_sr   <= '0;
      td_sr   <= '0;
      tclk_d  <= 1'b0;
      bit_stb <= 1'b0;
    end else begin
      tclk_sr <= {tclk_sr[SYNC_STAGES-2:0], tclk};
      ws_sr   <= {ws_sr[SYNC_STAGES-2:0], ws};
      td_sr   <= {td_sr[SYNC_STAGES-2:0], td};
      tclk_d  <= tclk_sr[SYNC_STAGES-1];
      bit_stb <= tclk_sr[SYNC_STAGES-1] & ~tclk_d;
    end
  end

  assign ws_s = ws_sr[SYNC_STAGES-1];
  assign td_s = td_sr[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: locks onto WS, deserializes left/right slots MSB first and
// presents each stereo frame on a valid/ready interface.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_SLOT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_tclk,
  input  logic                  i_ws,
  input  logic                  i_td,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overrun,
  output logic                  o_frame_err,
  output logic                  o_locked
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                  ws_s;
  logic                  td_s;
  logic                  bit_stb;
  logic                  ws_q;
  rx_state_t             state;
  rx_state_t             state_next;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] left_buf;
  logic                  shift_en;
  logic                  left_load;
  logic                  frame_done;
  logic                  frame_err;
  logic                  slot_ws;
  logic                  last_bit;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (i_clk),
    .rst    (i_rst),
    .tclk   (i_tclk),
    .ws     (i_ws),
    .td     (i_td),
    .ws_s   (ws_s),
    .td_s   (td_s),
    .bit_stb(bit_stb)
  );

  assign shreg_next = {shreg[DATA_WIDTH-2:0], td_s};
  assign last_bit   = (bit_cnt == LAST_CNT);

  // Within a slot WS holds the slot's own level; it flips only on the LSB,
  // which is why the final bit must see the opposite level.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    shift_en   = 1'b0;
    left_load  = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    slot_ws    = (state == RIGHT) ? WS_RIGHT : WS_LEFT;
    if (!i_enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = SYNC;
          cnt_next   = '0;
        end
        SYNC: begin
          if (bit_stb && ws_q == WS_RIGHT && ws_s == WS_LEFT) begin
            state_next = LEFT;
            cnt_next   = '0;
          end
        end
        LEFT, RIGHT: begin
          if (bit_stb) begin
            shift_en = 1'b1;
            if (last_bit && ws_s != slot_ws) begin
              cnt_next = '0;
              if (state == LEFT) begin
                left_load  = 1'b1;
                state_next = RIGHT;
              end else begin
                frame_done = 1'b1;
                state_next = LEFT;
              end
            end else if (last_bit || ws_s != slot_ws) begin
              frame_err  = 1'b1;
              state_next = SYNC;
              cnt_next   = '0;
            end else begin
              cnt_next = bit_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      left_buf    <= '0;
      ws_q        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= cnt_next;
      o_frame_err <= frame_err;
      if (bit_stb)   ws_q     <= ws_s;
      if (shift_en)  shreg    <= shreg_next;
      if (left_load) left_buf <= shreg_next;
    end
  end

  // A held frame is only replaced when the consumer takes it in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_left    <= '0;
      o_right   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (frame_done) begin
        if (!o_valid || i_ready) begin
          o_left  <= left_buf;
          o_right <= shreg_next;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_locked = (state == LEFT) || (state == RIGHT);

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives an I2S bus built from frame lists and
// compares received frames and status pulses against what those frames imply.
module tb_i2s_rx_deserializer;
  import i2s_pkg::*;

  localparam int DW = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          tclk = 1'b0;
  logic          ws = 1'b0;
  logic          td = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          valid;
  logic          overrun;
  logic          frame_err;
  logic          locked;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;
  int ovr_cnt = 0;
  int err_cnt = 0;
  int valid_rises = 0;
  int lock_falls = 0;
  logic prev_valid = 1'b0;
  logic prev_locked = 1'b0;
  logic [DW-1:0] got_l[$];
  logic [DW-1:0] got_r[$];
  logic [DW-1:0] obs;

  i2s_rx_deserializer #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (enable),
    .i_tclk     (tclk),
    .i_ws       (ws),
    .i_td       (td),
    .o_left     (left),
    .o_right    (right),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_overrun  (overrun),
    .o_frame_err(frame_err),
    .o_locked   (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Outputs only change on posedge, and ready only changes just after posedge,
  // so the negedge view matches what the next posedge will act on.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_l.push_back(left);
      got_r.push_back(right);
    end
    if (valid && !prev_valid) begin
      valid_rises = valid_rises + 1;
      valid_cyc = cyc;
    end
    if (!locked && prev_locked) lock_falls = lock_falls + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
    prev_valid = valid;
    prev_locked = locked;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One TCLK period of 8 i_clk cycles; data and WS change with the falling edge.
  task automatic tx_bit(input logic w, input logic d);
    tclk = 1'b0;
    ws = w;
    td = d;
    repeat (4) @(negedge clk);
    tclk = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_slot(input logic [DW-1:0] word, input logic right_slot, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) tx_bit(right_slot ? (i != 0) : (i == 0), word[i]);
  endtask

  task automatic tx_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    tx_slot(l, 1'b0, DW - 1, 0);
    tx_slot(r, 1'b1, DW - 1, 0);
  endtask

  task automatic tx_preamble();
    tx_bit(1'b1, 1'($urandom_range(0, 1)));
    tx_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_mon();
    ovr_cnt = 0;
    err_cnt = 0;
    valid_rises = 0;
    lock_falls = 0;
    got_l.delete();
    got_r.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    ready = 1'b1;
    tclk = 1'b0;
    ws = 1'b0;
    td = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] a_l, a_r, b_l, b_r, c_l, c_r;
    a_l = $urandom; a_r = $urandom; b_l = $urandom; b_r = $urandom;
    c_l = $urandom; c_r = $urandom;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({left, right} !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", left, right); end
    checks++; if ({valid, overrun, frame_err, locked} !== 4'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b want 0000", {valid, overrun, frame_err, locked}); end
    do_reset();
    @(posedge clk); #1 ready = 1'b0;
    tx_preamble();
    tx_frame(a_l, a_r);
    repeat (8) @(negedge clk);
    checks++; if (valid !== 1'b1 || left !== a_l || right !== a_r) begin fails++; $display("[TB] FAIL reset_pre_frame: got v=%b %h/%h want v=1 %h/%h", valid, left, right, a_l, a_r); end
    tx_slot(b_l, 1'b0, DW - 1, 12);
    #2 rst = 1'b1;
    #1;
    checks++; if ({valid, locked} !== 2'b00 || {left, right} !== '0) begin fails++; $display("[TB] FAIL reset_async: got v=%b lk=%b %h/%h want all 0", valid, locked, left, right); end
    @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    enable = 1'b1;
    clear_mon();
    tx_slot(b_l, 1'b0, 11, 0);
    tx_slot(b_r, 1'b1, DW - 1, 0);
    tx_frame(c_l, c_r);
    repeat (8) @(negedge clk);
    checks++; if (got_l.size() !== 1) begin fails++; $display("[TB] FAIL reset_resync_count: got %0d frames want 1", got_l.size()); end
    obs = (got_l.size() > 0) ? got_l[0] : 'x;
    checks++; if (obs !== c_l) begin fails++; $display("[TB] FAIL reset_resync_left: got %h want %h", obs, c_l); end
    obs = (got_r.size() > 0) ? got_r[0] : 'x;
    checks++; if (obs !== c_r) begin fails++; $display("[TB] FAIL reset_resync_right: got %h want %h", obs, c_r); end
  endtask

  task automatic test_nominal();
    do_reset();
    tx_preamble();
    tx_frame(32'hA5A5_0F0F, 32'h1234_5678);
    repeat (8) @(negedge clk);
    checks++; if (got_l.size() !== 1) begin fails++; $display("[TB] FAIL nominal_count: got %0d want 1", got_l.size()); end
    obs = (got_l.size() > 0) ? got_l[0] : 'x;
    checks++; if (obs !== 32'hA5A5_0F0F) begin fails++; $display("[TB] FAIL nominal_left: got %h want a5a50f0f", obs); end
    obs = (got_r.size() > 0) ? got_r[0] : 'x;
    checks++; if (obs !== 32'h1234_5678) begin fails++; $display("[TB] FAIL nominal_right: got %h want 12345678", obs); end
    checks++; if (valid_cyc - rise_cyc !== SS + 2) begin fails++; $display("[TB] FAIL nominal_latency: got %0d want %0d", valid_cyc - rise_cyc, SS + 2); end
    checks++; if (locked !== 1'b1 || err_cnt !== 0) begin fails++; $display("[TB] FAIL nominal_status: got lk=%b err=%0d want 1/0", locked, err_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(posedge clk); #1 ready = 1'b0;
    tx_preamble();
    tx_frame(32'd1, 32'd2);
    tx_frame(32'd3, 32'd4);
    repeat (8) @(negedge clk);
    checks++; if (valid !== 1'b1 || left !== 32'd1 || right !== 32'd2) begin fails++; $display("[TB] FAIL bp_held: got v=%b %h/%h want v=1 1/2", valid, left, right); end
    checks++; if (ovr_cnt !== 1) begin fails++; $display("[TB] FAIL bp_overrun: got %0d pulses want 1", ovr_cnt); end
    @(posedge clk); #1 ready = 1'b1;
    tx_frame(32'd5, 32'd6);
    repeat (8) @(negedge clk);
    checks++; if (got_l.size() !== 2) begin fails++; $display("[TB] FAIL bp_count: got %0d want 2", got_l.size()); end
    obs = (got_r.size() > 0) ? got_r[0] : 'x;
    checks++; if (obs !== 32'd2) begin fails++; $display("[TB] FAIL bp_first: got %h want 2", obs); end
    obs = (got_l.size() > 1) ? got_l[1] : 'x;
    checks++; if (obs !== 32'd5) begin fails++; $display("[TB] FAIL bp_second_left: got %h want 5", obs); end
    obs = (got_r.size() > 1) ? got_r[1] : 'x;
    checks++; if (obs !== 32'd6) begin fails++; $display("[TB] FAIL bp_second_right: got %h want 6", obs); end
    checks++; if (ovr_cnt !== 1) begin fails++; $display("[TB] FAIL bp_overrun_total: got %0d want 1", ovr_cnt); end
  endtask

  task automatic test_short_slot();
    logic [DW-1:0] junk_l, junk_r;
    junk_l = $urandom; junk_r = $urandom;
    do_reset();
    tx_preamble();
    tx_slot(junk_l, 1'b0, DW - 2, 0);
    repeat (2) @(negedge clk);
    checks++; if (err_cnt !== 1 || locked !== 1'b0) begin fails++; $display("[TB] FAIL short_err: got err=%0d lk=%b want 1/0", err_cnt, locked); end
    tx_slot(junk_r, 1'b1, DW - 1, 0);
    tx_frame(32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (8) @(negedge clk);
    checks++; if (got_l.size() !== 1 || lock_falls !== 1 || err_cnt !== 1) begin fails++; $display("[TB] FAIL short_recover: got frames=%0d falls=%0d err=%0d want 1/1/1", got_l.size(), lock_falls, err_cnt); end
    obs = (got_l.size() > 0) ? got_l[0] : 'x;
    checks++; if (obs !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL short_left: got %h want deadbeef", obs); end
    obs = (got_r.size() > 0) ? got_r[0] : 'x;
    checks++; if (obs !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL short_right: got %h want cafef00d", obs); end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] f0_l, f0_r, f1_l, f1_r, f2_l, f2_r;
    f0_l = $urandom; f0_r = $urandom; f1_l = $urandom; f1_r = $urandom;
    f2_l = $urandom; f2_r = $urandom;
    do_reset();
    @(posedge clk); #1 ready = 1'b0;
    tx_preamble();
    tx_frame(f0_l, f0_r);
    tx_slot(f1_l, 1'b0, DW - 1, 0);
    tx_slot(f1_r, 1'b1, DW - 1, DW - 10);
    @(posedge clk); #1 enable = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (locked !== 1'b0 || err_cnt !== 0) begin fails++; $display("[TB] FAIL en_idle: got lk=%b err=%0d want 0/0", locked, err_cnt); end
    checks++; if (valid !== 1'b1 || left !== f0_l || right !== f0_r || valid_rises !== 1) begin fails++; $display("[TB] FAIL en_hold: got v=%b %h/%h rises=%0d want v=1 %h/%h rises=1", valid, left, right, valid_rises, f0_l, f0_r); end
    @(posedge clk); #1 ready = 1'b1;
    repeat (3) @(negedge clk);
    obs = (got_l.size() > 0) ? got_l[0] : 'x;
    checks++; if (got_l.size() !== 1 || obs !== f0_l || valid !== 1'b0) begin fails++; $display("[TB] FAIL en_drain: got n=%0d %h v=%b want n=1 %h v=0", got_l.size(), obs, valid, f0_l); end
    @(posedge clk); #1 enable = 1'b1;
    tx_slot(f1_r, 1'b1, DW - 11, 0);
    tx_frame(f2_l, f2_r);
    repeat (8) @(negedge clk);
    checks++; if (got_l.size() !== 2 || ovr_cnt !== 0 || err_cnt !== 0) begin fails++; $display("[TB] FAIL en_resync_status: got n=%0d ovr=%0d err=%0d want 2/0/0", got_l.size(), ovr_cnt, err_cnt); end
    obs = (got_l.size() > 1) ? got_l[1] : 'x;
    checks++; if (obs !== f2_l) begin fails++; $display("[TB] FAIL en_resync_left: got %h want %h", obs, f2_l); end
    obs = (got_r.size() > 1) ? got_r[1] : 'x;
    checks++; if (obs !== f2_r) begin fails++; $display("[TB] FAIL en_resync_right: got %h want %h", obs, f2_r); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] l;
    do_reset();
    tx_preamble();
    for (int i = 0; i < 4; i++) begin
      l = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
      exp_l.push_back(l);
      exp_r.push_back(~l);
      tx_frame(l, ~l);
    end
    for (int i = 0; i < 5; i++) begin
      l = $urandom;
      exp_l.push_back(l);
      exp_r.push_back(32'($urandom));
      tx_frame(l, exp_r[exp_r.size() - 1]);
    end
    repeat (8) @(negedge clk);
    checks++; if (valid_rises !== 9 || got_l.size() !== 9) begin fails++; $display("[TB] FAIL b2b_count: got rises=%0d n=%0d want 9/9", valid_rises, got_l.size()); end
    checks++; if (ovr_cnt !== 0 || err_cnt !== 0) begin fails++; $display("[TB] FAIL b2b_status: got ovr=%0d err=%0d want 0/0", ovr_cnt, err_cnt); end
    for (int i = 0; i < 9; i++) begin
      obs = (got_l.size() > i) ? got_l[i] : 'x;
      checks++; if (obs !== exp_l[i]) begin fails++; $display("[TB] FAIL b2b_left[%0d]: got %h want %h", i, obs, exp_l[i]); end
      obs = (got_r.size() > i) ? got_r[i] : 'x;
      checks++; if (obs !== exp_r[i]) begin fails++; $display("[TB] FAIL b2b_right[%0d]: got %h want %h", i, obs, exp_r[i]); end
    end
  endtask

  initial begin
    $display("[TB] starting i2s_rx_deserializer bench");
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_slot();
    test_enable_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
